// File: rtl/adder_result_fifo.sv
// adder_result_fifo: FWFT valid/ready buffer for the adder sum stream, with occupancy count and sticky overflow
module adder_result_fifo #(
    parameter int g_data_width = 8,
    parameter int g_depth      = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    input  logic [g_data_width:0]       i_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [g_data_width:0]       o_data,
    output logic [$clog2(g_depth):0]    o_count,
    output logic                        o_full,
    output logic                        o_empty,
    output logic                        o_overflow,
    input  logic                        i_clr_ovf
);
    localparam int aw = $clog2(g_depth);
    logic [g_data_width:0] mem [g_depth];
    logic [aw-1:0] wr_ptr, rd_ptr;
    logic pop, push, drop;
    always_comb begin
        o_empty = o_count == '0;
        o_full  = o_count == (aw+1)'(g_depth);
        o_valid = !o_empty;
        o_data  = o_empty ? '0 : mem[rd_ptr];
        pop     = o_valid && i_ready;
        push    = i_valid && (!o_full || pop);
        drop    = i_valid && o_full && !pop;
    end
    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= i_data;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_count    <= '0;
            o_overflow <= 1'b0;
        end else begin
            wr_ptr     <= push ? wr_ptr + aw'(1) : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + aw'(1) : rd_ptr;
            o_count    <= o_count + (aw+1)'(push) - (aw+1)'(pop);
            o_overflow <= drop ? 1'b1 : (i_clr_ovf ? 1'b0 : o_overflow);
        end
    end
endmodule

// File: tb/tb_adder_result_fifo.sv
// tb_adder_result_fifo: randomized scoreboard bench against a queue-based reference model
module tb_adder_result_fifo;
    localparam int DW = 8;
    localparam int DEPTH = 8;
    logic clk = 1'b0;
    logic i_rst_n, i_valid, i_ready, i_clr_ovf;
    logic [DW:0] i_data;
    logic o_valid, o_full, o_empty, o_overflow;
    logic [DW:0] o_data;
    logic [$clog2(DEPTH):0] o_count;
    int n_chk = 0;
    int n_fail = 0;
    int model_cnt = 0;
    bit ovf_exp = 0;
    logic [DW:0] exp_q [$];

    adder_result_fifo #(.g_data_width(DW), .g_depth(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_count(o_count),
        .o_full(o_full), .o_empty(o_empty), .o_overflow(o_overflow), .i_clr_ovf(i_clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Monitor: every handshake seen by the DUT must deliver the oldest outstanding word
    always @(negedge clk) begin
        if (i_rst_n === 1'b1 && o_valid === 1'b1 && i_ready === 1'b1) begin
            chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0)
                chk("sb_data", 32'(o_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic check_state();
        chk("count", 32'(o_count), 32'(model_cnt));
        chk("overflow", 32'(o_overflow), 32'(ovf_exp));
        chk("empty", 32'(o_empty), 32'(model_cnt == 0));
        chk("full", 32'(o_full), 32'(model_cnt == DEPTH));
        chk("valid", 32'(o_valid), 32'(model_cnt != 0));
        if (model_cnt == 0)
            chk("data_empty", 32'(o_data), 0);
    endtask

    task automatic cycle(input logic v, input logic [DW:0] d, input logic r, input logic c);
        bit pop_m, push_m;
        i_valid = v; i_data = d; i_ready = r; i_clr_ovf = c;
        pop_m  = model_cnt > 0 && r;
        push_m = v && (model_cnt < DEPTH || pop_m);
        @(posedge clk);
        if (push_m)
            exp_q.push_back(d);
        ovf_exp = (v && !push_m) ? 1'b1 : (c ? 1'b0 : ovf_exp);
        model_cnt = model_cnt + int'(push_m) - int'(pop_m);
        #1;
        check_state();
    endtask

    task automatic do_reset(input int n);
        i_rst_n = 0; i_valid = 0; i_ready = 0; i_clr_ovf = 0; i_data = '0;
        repeat (n) @(posedge clk);
        #1;
        i_rst_n = 1;
        exp_q.delete();
        model_cnt = 0;
        ovf_exp = 0;
        check_state();
    endtask

    task automatic drain(input int n);
        repeat (n) cycle(0, '0, 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset(2);
        // single pass of the maximum sum
        cycle(1, 9'h1FE, 1, 0);
        chk("pass_valid", 32'(o_valid), 1);
        chk("pass_data", 32'(o_data), 32'h1FE);
        cycle(0, '0, 1, 0);
        // fill past capacity with no consumer
        for (int i = 1; i <= 9; i++) begin
            cycle(1, 9'(i), 0, 0);
            if (i == 8) chk("fill_full", 32'(o_full), 1);
        end
        chk("fill_ovf", 32'(o_overflow), 1);
        drain(8);
        // push and pop together while full
        do_reset(1);
        for (int i = 1; i <= 8; i++) cycle(1, 9'(i), 0, 0);
        cycle(1, 9'h055, 1, 0);
        chk("fullpp_cnt", 32'(o_count), 8);
        chk("fullpp_ovf", 32'(o_overflow), 0);
        drain(8);
        // rate-1 streaming through pointer wrap
        for (int i = 0; i < 20; i++) begin
            cycle(1, 9'($urandom), 1, 0);
            chk("rate1_cnt", 32'(o_count <= 1), 1);
        end
        drain(1);
        // reset in the middle of a stream with overflow set
        for (int i = 0; i < 9; i++) cycle(1, 9'($urandom), 0, 0);
        drain(3);
        do_reset(1);
        cycle(1, 9'h0AA, 0, 0);
        chk("post_rst_data", 32'(o_data), 32'h0AA);
        chk("post_rst_cnt", 32'(o_count), 1);
        drain(1);
        // overflow clear, and set winning over clear
        for (int i = 0; i < 9; i++) cycle(1, 9'($urandom), 0, 0);
        cycle(1, 9'($urandom), 0, 1);
        chk("set_over_clr", 32'(o_overflow), 1);
        cycle(0, '0, 0, 1);
        chk("clr_ovf", 32'(o_overflow), 0);
        drain(8);
        // random traffic
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 3) != 0), 9'($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 9) == 0));
        drain(DEPTH + 1);
        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
